mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 256; cycles spent in REQ before abort; 0 disables the timeout.
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  synchronous, active-low reset.
REQ-004 ex_mem_op  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE.
REQ-005 ex_mem_addr  in  32  effective address; ex_mem_store_data  in  32  store source.
REQ-006 ex_reg_write_data  in  32;  ex_reg_write_addr  in  5;  ex_reg_write_en  in  1  ALU result and destination.
REQ-007 flush  in  1  kill current instruction's write-back.
REQ-008 mem_reg_write_data  out  32;  mem_reg_write_addr  out  5;  mem_reg_write_en  out  1  to MEM/WB register.
REQ-009 stall_req  out  1  hold upstream stages and MEM/WB.
REQ-010 data_req  out  1;  data_we  out  1;  data_addr  out  32;  data_wstrb  out  4;  data_wdata  out  32  data-bus request.
REQ-011 data_ack  in  1;  data_rdata  in  32  data-bus response.
REQ-012 exc_adel  out  1;  exc_ades  out  1;  bad_vaddr  out  32;  bus_err  out  1  fault reporting.

Function
REQ-013 FSM SHALL have states IDLE, REQ, DONE; reset state IDLE.
REQ-014 IDLE, NONE op: mem_reg_write_* = ex_reg_write_* combinationally; stall_req=0; no bus activity.
REQ-015 IDLE, aligned load/store: stall_req=1 same cycle; next state REQ.
REQ-016 REQ: data_req=1, stall_req=1; data_addr = {ex_mem_addr[31:2],2'b00}; data_we=1 for stores only; inputs stay stable because of the stall.
REQ-017 Store strobes: SB 4'b0001<<addr[1:0], byte replicated x4; SH 4'b0011 or 4'b1100 by addr[1], halfword replicated x2; SW 4'b1111; loads 4'b0000.
REQ-018 REQ with data_ack=1: capture data_rdata into rdata_q; next state DONE; data_req drops the following cycle.
REQ-019 DONE: stall_req=0; loads write extended rdata_q with ex_reg_write_addr/en; stores pass ex_reg_write_*; next state IDLE unconditionally.
REQ-020 Load extension: LB/LBU select byte addr[1:0], sign/zero extend; LH/LHU select half addr[1], sign/zero extend; LW full word.
REQ-021 Minimum stall SHALL be 2 cycles (IDLE, REQ with immediate ack); each wait cycle without ack adds 1.
REQ-022 flush during IDLE/REQ/DONE: bus transaction in progress SHALL complete normally; mem_reg_write_en forced 0 through DONE (flush sticky until DONE exit).
REQ-023 ACK_TIMEOUT>0 and ACK_TIMEOUT cycles in REQ without ack: drop data_req, 1-cycle bus_err pulse, go DONE with mem_reg_write_en=0.
REQ-024 data_ack outside REQ SHALL be ignored.

Reset
REQ-025 rst=0 at any clock edge: state IDLE, rdata_q=0, timeout counter=0, flush flag cleared.
REQ-026 While rst=0 all outputs SHALL be 0, including mid-transaction; slave SHALL accept withdrawal of data_req on reset.

Configuration
REQ-027 Macro MEM_ALIGN_CHECK_EN defined: LH/LHU with addr[0]=1, or LW with addr[1:0]!=0, give exc_adel=1; SH/SW under the same conditions give exc_ades=1. Also bad_vaddr=ex_mem_addr, no bus request, stall_req=0, mem_reg_write_en=0, all in the same IDLE cycle.
REQ-028 Macro undefined: exc_adel, exc_ades, bad_vaddr tied 0; halfword ops ignore addr[0], word ops ignore addr[1:0]; access proceeds as aligned.

Verification
REQ-029 LW addr 0x100, ack in first REQ cycle, rdata 0xDEADBEEF -> stall_req high 2 cycles; DONE cycle mem_reg_write_data=0xDEADBEEF, en=1.
REQ-030 LB addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; LBU same access -> 0x00000080; LH addr 0x102 -> 0xFFFF8011.
REQ-031 SB addr 0x101, data 0x000000AB -> data_wstrb=4'b0010, data_wdata=0xABABABAB, data_we=1; SH addr 0x102, data 0x1234 -> wstrb 4'b1100, wdata 0x12341234.
REQ-032 LW with ack delayed 3 cycles and flush pulsed in REQ -> stall 5 cycles, DONE mem_reg_write_en=0; ACK_TIMEOUT=4, no ack -> bus_err pulse at cycle 5 of REQ, en=0.
REQ-033 MEM_ALIGN_CHECK_EN defined, LW addr 0x102 -> exc_adel=1, bad_vaddr=0x102, data_req=0, stall_req=0; undefined -> bus read at 0x100.
REQ-034 rst=0 asserted during REQ with ack pending -> next cycle IDLE, data_req=0, all outputs 0; first op after release behaves as REQ-029.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a stalling IDLE/REQ/DONE data-bus FSM, load extension and ack timeout.
// Defining MEM_ALIGN_CHECK_EN enables misaligned-access exceptions (exc_adel/exc_ades/bad_vaddr).
module mem_stage #(
  parameter int ACK_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_mem_store_data,
  input  logic [31:0] ex_reg_write_data,
  input  logic [4:0]  ex_reg_write_addr,
  input  logic        ex_reg_write_en,
  input  logic        flush,
  output logic [31:0] mem_reg_write_data,
  output logic [4:0]  mem_reg_write_addr,
  output logic        mem_reg_write_en,
  output logic        stall_req,
  output logic        data_req,
  output logic        data_we,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_ack,
  input  logic [31:0] data_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] bad_vaddr,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam int CW = ACK_TIMEOUT > 0 ? $clog2(ACK_TIMEOUT + 1) : 1;
  state_t state_q, state_d;
  logic [31:0] rdata_q, rdata_d, ld;
  logic [CW-1:0] cnt_q, cnt_d;
  logic flush_q, flush_d, err_q, err_d;
  logic is_load, is_store, misal, timeout;
  logic [7:0] lb;
  logic [15:0] lh;
  assign is_load = ex_mem_op inside {[4'd1:4'd5]};
  assign is_store = ex_mem_op inside {[4'd6:4'd8]};
`ifdef MEM_ALIGN_CHECK_EN
  assign misal = ((ex_mem_op inside {4'd3, 4'd4, 4'd7}) && ex_mem_addr[0]) ||
                 ((ex_mem_op inside {4'd5, 4'd8}) && ex_mem_addr[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif
  assign timeout = (ACK_TIMEOUT != 0) && (cnt_q == CW'(ACK_TIMEOUT));
  assign lb = rdata_q[{ex_mem_addr[1:0], 3'b000} +: 8];
  assign lh = ex_mem_addr[1] ? rdata_q[31:16] : rdata_q[15:0];
  assign ld = ex_mem_op == 4'd1 ? {{24{lb[7]}}, lb} :
              ex_mem_op == 4'd2 ? {24'b0, lb} :
              ex_mem_op == 4'd3 ? {{16{lh[15]}}, lh} :
              ex_mem_op == 4'd4 ? {16'b0, lh} : rdata_q;
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    cnt_d = '0;
    err_d = err_q;
    stall_req = 1'b0;
    data_req = 1'b0;
    data_we = 1'b0;
    data_addr = '0;
    data_wstrb = '0;
    data_wdata = '0;
    exc_adel = 1'b0;
    exc_ades = 1'b0;
    bad_vaddr = '0;
    bus_err = 1'b0;
    mem_reg_write_data = ex_reg_write_data;
    mem_reg_write_addr = ex_reg_write_addr;
    mem_reg_write_en = ex_reg_write_en;
    case (state_q)
      IDLE: begin
        if (misal) begin
          exc_adel = is_load;
          exc_ades = is_store;
          bad_vaddr = ex_mem_addr;
          mem_reg_write_en = 1'b0;
        end else if (is_load || is_store) begin
          stall_req = 1'b1;
          mem_reg_write_en = 1'b0;
          state_d = REQ;
        end
      end
      REQ: begin
        stall_req = 1'b1;
        mem_reg_write_en = 1'b0;
        if (timeout) begin
          bus_err = 1'b1;
          err_d = 1'b1;
          state_d = DONE;
        end else begin
          data_req = 1'b1;
          data_we = is_store;
          data_addr = {ex_mem_addr[31:2], 2'b00};
          data_wstrb = ex_mem_op == 4'd6 ? 4'b0001 << ex_mem_addr[1:0] :
                       ex_mem_op == 4'd7 ? (ex_mem_addr[1] ? 4'b1100 : 4'b0011) :
                       ex_mem_op == 4'd8 ? 4'b1111 : 4'b0000;
          data_wdata = ex_mem_op == 4'd6 ? {4{ex_mem_store_data[7:0]}} :
                       ex_mem_op == 4'd7 ? {2{ex_mem_store_data[15:0]}} :
                       ex_mem_op == 4'd8 ? ex_mem_store_data : 32'h0;
          cnt_d = cnt_q + 1'b1;
          if (data_ack) begin
            rdata_d = data_rdata;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d = 1'b0;
        mem_reg_write_data = is_load ? ld : ex_reg_write_data;
        mem_reg_write_en = ex_reg_write_en & ~err_q;
      end
      default: state_d = IDLE;
    endcase
    // flush stays latched for the whole transaction and is released on return to IDLE
    flush_d = (state_d == IDLE) ? 1'b0 : (flush_q | flush);
    if (flush || flush_q) mem_reg_write_en = 1'b0;
    if (!rst) begin
      stall_req = 1'b0;
      data_req = 1'b0;
      data_we = 1'b0;
      data_addr = '0;
      data_wstrb = '0;
      data_wdata = '0;
      exc_adel = 1'b0;
      exc_ades = 1'b0;
      bad_vaddr = '0;
      bus_err = 1'b0;
      mem_reg_write_data = '0;
      mem_reg_write_addr = '0;
      mem_reg_write_en = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
      cnt_q <= '0;
      flush_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      cnt_q <= cnt_d;
      flush_q <= flush_d;
      err_q <= err_d;
    end
  end
endmodule
